// File: rtl/sw_filter_multi.sv
// -----------------------------------------------------------------------------
// sw_filter_multi
//
// Multi-channel switch/status debouncer. Each raw input is synchronised,
// turned into an "active" sample and counted over a window of WIN enabled
// cycles that all channels share. At each window end the per-channel
// debounced state is updated with hysteresis. Assertion needs at least THD_ON
// active samples. Deassertion needs at most THD_OFF active samples.
//
// Ports:
//   clk_in      sample clock
//   rstn_i      asynchronous active-low reset
//   en_i        filter enable; low clears the window and per-channel counts
//   sw_in       [CH] raw asynchronous switch inputs
//   sw_state    [CH] debounced state, 1 = active
//   rise_o      [CH] one-cycle pulse on a 0->1 change of sw_state
//   fall_o      [CH] one-cycle pulse on a 1->0 change of sw_state
//   win_done_o  one-cycle pulse after every evaluated window
// -----------------------------------------------------------------------------
module sw_filter_multi #(
   parameter int CH          = 4,
   parameter int WIN         = 10,
   parameter int WIN_W       = 8,
   parameter int THD_ON      = 7,
   parameter int THD_OFF     = 3,
   parameter int ACTIVE_LOW  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk_in,
   input  logic          rstn_i,
   input  logic          en_i,
   input  logic [CH-1:0] sw_in,
   output logic [CH-1:0] sw_state,
   output logic [CH-1:0] rise_o,
   output logic [CH-1:0] fall_o,
   output logic          win_done_o
);

   // Idle (inactive) input level. The synchronisers reset to this level so
   // that no spurious active samples appear after reset.
   localparam logic             INACT_LVL = (ACTIVE_LOW != 0);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN - 1);
   localparam logic [WIN_W:0]   THD_ON_V  = (WIN_W + 1)'(THD_ON);
   localparam logic [WIN_W:0]   THD_OFF_V = (WIN_W + 1)'(THD_OFF);

   // ---------------------------------------------------------------------
   // Shared window counter
   // ---------------------------------------------------------------------
   logic [WIN_W-1:0] wcnt_q, wcnt_d;
   logic             win_done_q, win_done_d;
   logic             win_end;

   always_comb begin
      win_end    = en_i && (wcnt_q == WIN_LAST);
      win_done_d = win_end;
      if (!en_i || win_end) begin
         // A disabled filter restarts from a fresh window. A partial window
         // is never evaluated.
         wcnt_d = '0;
      end else begin
         wcnt_d = wcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rstn_i) begin
      if (!rstn_i) begin
         wcnt_q     <= '0;
         win_done_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         win_done_q <= win_done_d;
      end
   end

   assign win_done_o = win_done_q;

   // ---------------------------------------------------------------------
   // Per-channel synchroniser, active counter and hysteresis state
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [WIN_W-1:0]       acnt_q, acnt_d;
      logic                   state_q, state_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   act;
      logic [WIN_W:0]         tot;

      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], sw_in[gi]};
         act    = sync_q[SYNC_STAGES-1] ^ INACT_LVL;
         // The window-end sample is still in flight. Adding it here makes
         // tot cover exactly WIN samples.
         tot     = (WIN_W + 1)'(acnt_q) + (WIN_W + 1)'(act);
         acnt_d  = acnt_q;
         state_d = state_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         if (!en_i) begin
            acnt_d = '0;
         end else if (win_end) begin
            acnt_d = '0;
            if (!state_q && (tot >= THD_ON_V)) begin
               state_d = 1'b1;
               rise_d  = 1'b1;
            end else if (state_q && (tot <= THD_OFF_V)) begin
               state_d = 1'b0;
               fall_d  = 1'b1;
            end
         end else begin
            acnt_d = acnt_q + WIN_W'(act);
         end
      end

      always_ff @(posedge clk_in or negedge rstn_i) begin
         if (!rstn_i) begin
            sync_q  <= {SYNC_STAGES{INACT_LVL}};
            acnt_q  <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            sync_q  <= sync_d;
            acnt_q  <= acnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      assign sw_state[gi] = state_q;
      assign rise_o[gi]   = rise_q;
      assign fall_o[gi]   = fall_q;
   end

endmodule

// File: tb/tb_sw_filter_multi.sv
// -----------------------------------------------------------------------------
// tb_sw_filter_multi
//
// Bench for sw_filter_multi with default parameters. A reference model
// counts active samples per window, with inputs delayed SYNC clocks. Its
// outputs are compared with the DUT on every falling clock edge. Directed
// literal checks pin the press, bounce, multi-channel, enable-freeze and
// mid-window reset behaviour. Random window patterns and random per-cycle
// noise follow.
// -----------------------------------------------------------------------------
module tb_sw_filter_multi;
   localparam int CH         = 4;
   localparam int WIN        = 10;
   localparam int WIN_W      = 8;
   localparam int THD_ON     = 7;
   localparam int THD_OFF    = 3;
   localparam int ACTIVE_LOW = 1;
   localparam int SYNC       = 2;

   logic          clk_in = 1'b0;
   logic          rstn_i;
   logic          en_i;
   logic [CH-1:0] sw_in;
   logic [CH-1:0] sw_state, rise_o, fall_o;
   logic          win_done_o;

   sw_filter_multi #(
      .CH(CH), .WIN(WIN), .WIN_W(WIN_W), .THD_ON(THD_ON), .THD_OFF(THD_OFF),
      .ACTIVE_LOW(ACTIVE_LOW), .SYNC_STAGES(SYNC)
   ) dut (
      .clk_in(clk_in), .rstn_i(rstn_i), .en_i(en_i), .sw_in(sw_in),
      .sw_state(sw_state), .rise_o(rise_o), .fall_o(fall_o),
      .win_done_o(win_done_o)
   );

   initial forever #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model. A sample reaches the filter SYNC clocks after capture.
   // Every WIN enabled samples form one window.
   // ---------------------------------------------------------------------
   localparam logic [CH-1:0] INACT_V = (ACTIVE_LOW != 0) ? '1 : '0;
   logic [CH-1:0] hist[$];
   int            nsamp;
   int            cnt[CH];
   logic [CH-1:0] e_state = '0, e_rise = '0, e_fall = '0;
   logic          e_done = 1'b0;

   initial begin
      logic [CH-1:0] samp, act;
      forever begin
         @(posedge clk_in or negedge rstn_i);
         if (!rstn_i) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(INACT_V);
            nsamp = 0;
            for (int c = 0; c < CH; c++) cnt[c] = 0;
            e_state = '0; e_rise = '0; e_fall = '0; e_done = 1'b0;
         end else begin
            samp = hist.pop_front();
            hist.push_back(sw_in);
            act = (ACTIVE_LOW != 0) ? ~samp : samp;
            e_rise = '0; e_fall = '0; e_done = 1'b0;
            if (!en_i) begin
               nsamp = 0;
               for (int c = 0; c < CH; c++) cnt[c] = 0;
            end else begin
               nsamp++;
               for (int c = 0; c < CH; c++) cnt[c] += int'(act[c]);
               if (nsamp == WIN) begin
                  e_done = 1'b1;
                  for (int c = 0; c < CH; c++) begin
                     if (!e_state[c] && cnt[c] >= THD_ON) begin
                        e_state[c] = 1'b1; e_rise[c] = 1'b1;
                     end else if (e_state[c] && cnt[c] <= THD_OFF) begin
                        e_state[c] = 1'b0; e_fall[c] = 1'b1;
                     end
                     cnt[c] = 0;
                  end
                  nsamp = 0;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk_in);
      if (chk_on) begin
         check("cycle_outputs",
               32'({sw_state, rise_o, fall_o, win_done_o}),
               32'({e_state, e_rise, e_fall, e_done}));
         if (win_done_o === 1'b1) done_cnt++;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   int kcnt[CH];

   task automatic set_k(input int k0, input int k1, input int k2, input int k3);
      kcnt[0] = k0; kcnt[1] = k1; kcnt[2] = k2; kcnt[3] = k3;
   endtask

   // Drives one window-aligned block of WIN cycles. It is entered at
   // posedge+3 of the cycle before the window's first edge. kcnt[c] >= WIN
   // holds the channel active for the whole block. Other counts place that
   // many active samples in positions 0..WIN-3. The sync delay then keeps
   // all of them inside the same filter window.
   task automatic run_block();
      logic [WIN-1:0] mask [CH];
      int pos[WIN-2];
      int j, t;
      for (int c = 0; c < CH; c++) begin
         mask[c] = '0;
         if (kcnt[c] >= WIN) begin
            mask[c] = '1;
         end else begin
            for (int i = 0; i < WIN - 2; i++) pos[i] = i;
            for (int i = WIN - 3; i > 0; i--) begin
               j = int'($urandom_range(i, 0));
               t = pos[i]; pos[i] = pos[j]; pos[j] = t;
            end
            for (int i = 0; i < kcnt[c]; i++) mask[c][pos[i]] = 1'b1;
         end
      end
      for (int p = 0; p < WIN; p++) begin
         for (int c = 0; c < CH; c++)
            sw_in[c] = (ACTIVE_LOW != 0) ? ~mask[c][p] : mask[c][p];
         @(posedge clk_in);
         #3;
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #3;
   endtask

   localparam logic ACT_LVL = (ACTIVE_LOW == 0);
   int bounce_k[7] = '{7, 6, 6, 3, 4, 5, 6};

   initial begin
      rstn_i = 1'b0;
      en_i   = 1'b1;
      sw_in  = INACT_V;
      for (int c = 0; c < CH; c++) kcnt[c] = 0;
      tick();
      chk_on = 1'b1;
      tick(); tick();
      check("reset_outputs", 32'({sw_state, rise_o, fall_o, win_done_o}), 32'h0);
      rstn_i = 1'b1;
      done_cnt = 0;

      // Idle: no state change, win_done every WIN cycles
      set_k(0, 0, 0, 0);
      for (int b = 0; b < 5; b++) run_block();
      check("idle_done_count", 32'(done_cnt), 32'd4);
      check("idle_done_last", 32'(win_done_o), 32'h1);
      check("idle_state", 32'(sw_state), 32'h0);

      // Clean press on ch0 (8 of 10 samples in the first window)
      set_k(WIN, 0, 0, 0);
      run_block();
      check("press_rise", 32'({sw_state, rise_o, fall_o}), 32'h110);
      run_block();
      check("press_hold", 32'({sw_state, rise_o, fall_o}), 32'h100);

      // Bounce on ch1 with hysteresis
      for (int w = 0; w < 7; w++) begin
         set_k(WIN, bounce_k[w], int'($urandom_range(8, 0)), int'($urandom_range(8, 0)));
         run_block();
         case (w)
            0:       check("bounce_rise7", 32'({sw_state[1], rise_o[1]}), 32'h3);
            1, 2:    check("bounce_hold6", 32'({sw_state[1], rise_o[1], fall_o[1]}), 32'h4);
            3:       check("bounce_fall3", 32'({sw_state[1], fall_o[1]}), 32'h1);
            default: check("bounce_low", 32'({sw_state[1], rise_o[1]}), 32'h0);
         endcase
      end

      // Independent channels on the same evaluation edge
      set_k(WIN - 2, 5, 0, 0);
      run_block();
      set_k(2, 5, 7, 8);
      run_block();
      check("multi_edges", 32'({rise_o, fall_o, win_done_o}), 32'b1100_0001_1);

      // Enable freeze: 5 active ch0 samples counted, then disabled
      sw_in = INACT_V;
      for (int i = 0; i < 5; i++) begin
         sw_in[0] = ACT_LVL;
         tick();
      end
      sw_in = INACT_V;
      tick(); tick();
      en_i = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("freeze_hold", 32'({sw_state, rise_o, fall_o, win_done_o}), 32'b1100_0000_0000_0);
      en_i = 1'b1;
      set_k(4, 0, 0, 0);
      run_block();
      check("freeze_fresh_window", 32'({sw_state, rise_o, fall_o, win_done_o}), 32'b0000_0000_1100_1);

      // Mid-window asynchronous reset
      set_k(WIN - 2, 0, 0, 0);
      run_block();
      check("prereset_rise", 32'({sw_state, rise_o}), 32'h11);
      for (int i = 0; i < 9; i++) begin
         sw_in[0] = ACT_LVL;
         tick();
      end
      rstn_i = 1'b0;
      #1;
      check("async_reset", 32'({sw_state, rise_o, fall_o, win_done_o}), 32'h0);
      @(posedge clk_in);
      @(posedge clk_in);
      #3;
      rstn_i = 1'b1;
      set_k(WIN, 0, 0, 0);
      run_block();
      check("post_reset_rise", 32'({sw_state, rise_o}), 32'h11);

      // Random window-aligned patterns
      for (int b = 0; b < 30; b++) begin
         for (int c = 0; c < CH; c++) kcnt[c] = int'($urandom_range(8, 0));
         run_block();
      end

      // Random per-cycle noise with occasional enable drops
      for (int i = 0; i < 300; i++) begin
         sw_in = CH'($urandom);
         en_i  = ($urandom_range(19, 0) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
